jk_mod_counter: RTL and testbench
=================================

Name: jk_mod_counter

Overview:
- Synchronous modulo-N up/down counter. Every state bit is held in a JK cell, and the block generates each cell's J/K excitation.
- Sits directly upstream of the JK storage stage. It computes the J/K drive for each bit and owns the resulting state.
- Used as a lab-bench decade/hex counter and as a JK excitation-logic reference for later counter and sequencer labs.

Parameters:
- WIDTH, 4, number of state bits (JK cells).
- MODULUS, 10, count range 0..MODULUS-1. Legal range is 2 <= MODULUS <= 2**WIDTH; any other value is an elaboration error.

Ports:
- clk  input  1  rising-edge clock, single clock domain.
- rst  input  1  synchronous, active-high reset.
- en  input  1  count enable; one step per rising edge while high.
- up  input  1  direction: 1 = increment, 0 = decrement.
- load  input  1  synchronous parallel load of din.
- din  input  WIDTH  load value.
- q  output  WIDTH  current count, taken directly from the JK cells.
- qbar  output  WIDTH  bitwise ~q.
- tc  output  1  terminal count, combinational. High when (up && q==MODULUS-1) or (!up && q==0).
- wrap  output  1  registered one-cycle pulse, asserted the cycle after a wrap step.

Behaviour:
- Interface decided: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset state, on a rising edge with rst=1: q=0, qbar=all ones, wrap=0. tc then follows q (tc=1 if up=0).
- Priority each edge: rst > load > en > hold.
- Load:
  - The next state is din if din < MODULUS, otherwise MODULUS-1 (clamp).
  - Load never asserts wrap.
  - load together with en: load wins and no count occurs.
- Count, en=1:
  - Up: q+1, except q==MODULUS-1 goes to 0.
  - Down: q-1, except q==0 goes to MODULUS-1.
  - A wrap step sets wrap=1 on the following cycle only.
- Hold, en=0 and load=0: every cell gets J=K=0 and q is unchanged; wrap=0.
- Excitation rules, per bit i, with next state N:
  - Non-wrap count: J=K=(q[i] != N[i]), i.e. toggle form.
  - Load and wrap: J=N[i], K=~N[i], i.e. set/reset form.
  - Hold: J=K=0.
- Latency: q updates one edge after the control inputs; wrap lags the wrapping edge by one cycle; tc has zero latency.
- Direction change mid-count takes effect on the next edge and needs no idle cycle.
- Illegal state, only reachable when MODULUS < 2**WIDTH (e.g. via forced values): the next counting edge in either direction sets q to 0.
- Reset mid-operation overrides load/en on the same edge and clears a pending wrap pulse.

Optional Feature:
- Macro: JK_MOD_COUNTER_SATURATE_EN.
- Defined:
  - Counting saturates: up at MODULUS-1 holds and down at 0 holds, with J=K=0 on all cells.
  - wrap is tied to 0.
  - tc is unchanged and acts as a saturation flag.
- Undefined: wrap-around behaviour as described above.

Decomposition:
- Shared package jk_pkg:
  - jk_cmd_e enum: HOLD=2'b00, RESET0=2'b01, SET1=2'b10, TOGGLE=2'b11, in {J,K} bit order.
  - Default constants JK_CNT_WIDTH=4 and JK_CNT_MODULUS=10.
  - Function jk_excite(cur,next) returning jk_cmd_e.
- Sub-module: jk_cell.
  - One-bit JK storage with synchronous active-high reset.
  - Instantiated WIDTH times via generate.
  - The counter top holds the excitation logic, load clamp, tc and the wrap register.

Test Plan:
1. Reset then count up: rst=1 for 2 edges, then en=1, up=1 for 12 edges. Expect q=0,1..9,0,1,2; wrap=1 only the cycle after 9->0; tc=1 while q=9.
2. Count down from reset: en=1, up=0. Expect q=0->9->8->7; wrap=1 the cycle after 0->9; tc=1 while q=0.
3. Load and clamp: load din=4'd6 gives q=6. load din=4'd13 gives q=9. load=1 with en=1 and din=3 gives q=3, not 4; wrap stays 0.
4. Hold and direction change: from q=5 with en=0 for 3 edges, q stays 5. Then en=1, up toggled each edge gives 6,5,6,5.
5. Reset mid-wrap: at q=9, up, en=1, assert rst on the same edge. Expect q=0 and wrap=0 on the following cycle.
6. With JK_MOD_COUNTER_SATURATE_EN, MODULUS=10: up from 7 gives 8,9,9,9 with wrap always 0. Down from 1 gives 0,0.

Source files
------------

// File: rtl/jk_mod_counter_pkg.sv
// Shared JK definitions: cell command encoding, default counter sizing and
// the toggle-form excitation helper used by jk_mod_counter.
package jk_pkg;

  // Encoded as {J,K}
  typedef enum logic [1:0] {
    HOLD   = 2'b00,
    RESET0 = 2'b01,
    SET1   = 2'b10,
    TOGGLE = 2'b11
  } jk_cmd_e;

  localparam int JK_CNT_WIDTH   = 4;
  localparam int JK_CNT_MODULUS = 10;

  function automatic jk_cmd_e jk_excite(input logic cur, input logic nxt);
    return (cur != nxt) ? TOGGLE : HOLD;
  endfunction

endpackage

// File: rtl/jk_mod_counter_cell.sv
// jk_cell: one-bit JK storage element with synchronous active-high reset.
module jk_cell
  import jk_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic j,
  input  logic k,
  output logic q
);

  // JK state update: hold, reset, set or toggle according to {J,K}
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= 1'b0;
    end else begin
      case ({j, k})
        HOLD:    q <= q;
        RESET0:  q <= 1'b0;
        SET1:    q <= 1'b1;
        TOGGLE:  q <= ~q;
        default: q <= 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/jk_mod_counter.sv
// Modulo-MODULUS up/down counter stored in WIDTH JK cells.
// Define JK_MOD_COUNTER_SATURATE_EN to saturate at the ends instead of wrapping.
module jk_mod_counter
  import jk_pkg::*;
#(
  parameter int WIDTH   = JK_CNT_WIDTH,
  parameter int MODULUS = JK_CNT_MODULUS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

  if ((MODULUS < 2) || (MODULUS > (2 ** WIDTH))) begin : g_bad_modulus
    $error("jk_mod_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
  end

  logic [WIDTH-1:0] next;
  logic [WIDTH-1:0] clamp;
  logic             form_sr;
  logic             step_wrap;
  logic [1:0]       jk [WIDTH];

  assign clamp = ({1'b0, din} < (WIDTH+1)'(MODULUS)) ? din : MAX_VAL;

  // Next-state selection and per-bit J/K excitation
  always_comb begin
    next      = q;
    form_sr   = 1'b0;
    step_wrap = 1'b0;
    if (load) begin
      next    = clamp;
      form_sr = 1'b1;
    end else if (en) begin
      if (q > MAX_VAL) begin
        next    = '0;
        form_sr = 1'b1;
      end else if (up) begin
        if (q == MAX_VAL) begin
`ifdef JK_MOD_COUNTER_SATURATE_EN
          next = q;
`else
          next      = '0;
          form_sr   = 1'b1;
          step_wrap = 1'b1;
`endif
        end else begin
          next = q + WIDTH'(1);
        end
      end else begin
        if (q == '0) begin
`ifdef JK_MOD_COUNTER_SATURATE_EN
          next = q;
`else
          next      = MAX_VAL;
          form_sr   = 1'b1;
          step_wrap = 1'b1;
`endif
        end else begin
          next = q - WIDTH'(1);
        end
      end
    end else begin
      next = q;
    end

    for (int i = 0; i < WIDTH; i++) begin
      if (form_sr) begin
        jk[i] = next[i] ? SET1 : RESET0;
      end else begin
        jk[i] = jk_excite(q[i], next[i]);
      end
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_cell
    jk_cell u_cell (
      .clk (clk),
      .rst (rst),
      .j   (jk[g][1]),
      .k   (jk[g][0]),
      .q   (q[g])
    );
  end

  assign qbar = ~q;
  assign tc   = up ? (q == MAX_VAL) : (q == '0);

  // One-cycle pulse following a wrap step
  always_ff @(posedge clk) begin
    if (rst) begin
      wrap <= 1'b0;
    end else begin
      wrap <= step_wrap;
    end
  end

endmodule

// File: tb/tb_jk_mod_counter.sv
// Directed self-checking bench for jk_mod_counter (WIDTH=4, MODULUS=10).
module tb_jk_mod_counter;

  logic       clk = 1'b0;
  logic       rst, en, up, load;
  logic [3:0] din;
  logic [3:0] q, qbar;
  logic       tc, wrap;

  int n_checks = 0;
  int n_fail   = 0;

  jk_mod_counter #(.WIDTH(4), .MODULUS(10)) dut (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .up   (up),
    .load (load),
    .din  (din),
    .q    (q),
    .qbar (qbar),
    .tc   (tc),
    .wrap (wrap)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; din = 4'd0;

    // reset
    step();
    step();
    check_eq("rst_q", 32'(q), 32'd0);
    check_eq("rst_qbar", 32'(qbar), 32'd15);
    check_eq("rst_wrap", 32'(wrap), 32'd0);
    check_eq("rst_tc_up", 32'(tc), 32'd0);

`ifndef JK_MOD_COUNTER_SATURATE_EN
    // count up 12 edges: 1..9,0,1,2
    rst = 1'b0; en = 1'b1; up = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      check_eq("up_q", 32'(q), 32'(k % 10));
      check_eq("up_wrap", 32'(wrap), (k == 10) ? 32'd1 : 32'd0);
      check_eq("up_tc", 32'(tc), (k == 9) ? 32'd1 : 32'd0);
    end

    // count down from reset
    rst = 1'b1; en = 1'b0;
    step();
    rst = 1'b0; up = 1'b0;
    #1;
    check_eq("dn_tc_at0", 32'(tc), 32'd1);
    en = 1'b1;
    step();
    check_eq("dn_q9", 32'(q), 32'd9);
    check_eq("dn_wrap9", 32'(wrap), 32'd1);
    check_eq("dn_tc9", 32'(tc), 32'd0);
    step();
    check_eq("dn_q8", 32'(q), 32'd8);
    check_eq("dn_wrap8", 32'(wrap), 32'd0);
    step();
    check_eq("dn_q7", 32'(q), 32'd7);

    // load and clamp
    en = 1'b0; up = 1'b1; load = 1'b1; din = 4'd6;
    step();
    check_eq("ld6_q", 32'(q), 32'd6);
    check_eq("ld6_wrap", 32'(wrap), 32'd0);
    din = 4'd13;
    step();
    check_eq("ld13_q", 32'(q), 32'd9);
    din = 4'd10;
    step();
    check_eq("ld10_q", 32'(q), 32'd9);
    din = 4'd3; en = 1'b1;
    step();
    check_eq("ld_en_q", 32'(q), 32'd3);
    check_eq("ld_en_wrap", 32'(wrap), 32'd0);
    check_eq("ld_en_qbar", 32'(qbar), 32'd12);

    // hold then direction change
    din = 4'd5; en = 1'b0;
    step();
    load = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check_eq("hold_q", 32'(q), 32'd5);
      check_eq("hold_wrap", 32'(wrap), 32'd0);
    end
    en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      up = (k % 2 == 0) ? 1'b1 : 1'b0;
      step();
      check_eq("dir_q", 32'(q), (k % 2 == 0) ? 32'd6 : 32'd5);
    end

    // reset on the wrapping edge
    load = 1'b1; din = 4'd9; en = 1'b0; up = 1'b1;
    step();
    load = 1'b0; en = 1'b1; rst = 1'b1;
    step();
    check_eq("rstwrap_q", 32'(q), 32'd0);
    check_eq("rstwrap_wrap", 32'(wrap), 32'd0);
    rst = 1'b0; en = 1'b0;
    step();
    check_eq("rstwrap_wrap2", 32'(wrap), 32'd0);

    // wrap pulse lasts one cycle only
    load = 1'b1; din = 4'd9;
    step();
    load = 1'b0; en = 1'b1;
    step();
    check_eq("pulse_q", 32'(q), 32'd0);
    check_eq("pulse_on", 32'(wrap), 32'd1);
    step();
    check_eq("pulse_off", 32'(wrap), 32'd0);
`else
    // saturation: up from 7
    rst = 1'b0; load = 1'b1; din = 4'd7;
    step();
    load = 1'b0; en = 1'b1; up = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      check_eq("sat_up_q", 32'(q), (k == 0) ? 32'd8 : 32'd9);
      check_eq("sat_up_wrap", 32'(wrap), 32'd0);
      check_eq("sat_up_tc", 32'(tc), (k == 0) ? 32'd0 : 32'd1);
    end
    load = 1'b1; din = 4'd1; en = 1'b0;
    step();
    load = 1'b0; en = 1'b1; up = 1'b0;
    for (int k = 0; k < 2; k++) begin
      step();
      check_eq("sat_dn_q", 32'(q), 32'd0);
      check_eq("sat_dn_wrap", 32'(wrap), 32'd0);
      check_eq("sat_dn_tc", 32'(tc), 32'd1);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
